rlbp_code_capture: RTL

Readback end of the RLBP pixel-array control path. The sequencer drives the analog front end, which returns one comparator bit (CMP) per photodiode comparison. This block samples those bits and assembles each frame's NUM_PD results into an LBP code word. Code words are buffered in a FIFO that the management core reads over a Wishbone slave port, and an interrupt is raised while data is waiting.

---
 rtl/rlbp_code_capture.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/rlbp_code_capture.sv
// rlbp_code_capture: captures the comparator bits of each RLBP frame into an
// LBP code word, buffers the words in a FIFO and exposes them on a Wishbone
// slave port with a level interrupt.
// Optional build macro: RLBP_POPCOUNT_EN (adds popcount/uniform field [23:16]).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for frame_start_i
// S_ARMED  | frame open, waiting for the next cmp_strobe_i
// S_SETTLE | counting down the comparator settle time
// S_SAMPLE | shift the synchronized comparator bit into the code
// S_PUSH   | write the completed code word into the FIFO
module rlbp_code_capture #(
  parameter int          NUM_PD        = 12,
  parameter int          FIFO_DEPTH    = 8,
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0100
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmp_i,
  input  logic        cmp_strobe_i,
  input  logic        frame_start_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_SETTLE, S_SAMPLE, S_PUSH
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_PD-1:0]   shift_q, shift_d;
  logic [4:0]          bits_q, bits_d;
  logic [7:0]          seq_q, seq_d;
  logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                ovf_q, ovf_d;
  logic                irq_en_q, irq_en_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic                irq_q, irq_d;
  logic                cmp_s1_q, cmp_s1_d, cmp_s2_q, cmp_s2_d;
  logic [7:0]          field_q, field_d;

  logic [31:0]         mem_q [FIFO_DEPTH];
  logic [31:0]         wdata, head, rdata;
  logic [AW:0]         level;
  logic [4:0]          level5;
  logic                empty, full, busy;
  logic                hit, req, pop, ctrl_wr, push_req, push, ovf_set;
  logic [1:0]          reg_sel;
  logic                unused_bits;

  assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:2], wbs_adr_i[1:0]};

`ifdef RLBP_POPCOUNT_EN
  // Popcount in [4:0], uniform flag (<=2 circular transitions) in [7].
  function automatic logic [7:0] lbp_field(input logic [NUM_PD-1:0] c);
    logic [4:0] ones;
    logic [4:0] trans;
    ones  = '0;
    trans = '0;
    for (int i = 0; i < NUM_PD; i++) begin
      ones  = ones + 5'(c[i]);
      trans = trans + 5'(c[i] ^ c[(i + 1) % NUM_PD]);
    end
    return {(trans <= 5'd2), 2'b00, ones};
  endfunction
`endif

  // FIFO status and bus decode.
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    level   = wr_ptr_q - rd_ptr_q;
    level5  = 5'(level);
    busy    = (state_q != S_IDLE);
    hit     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    req     = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
    reg_sel = wbs_adr_i[3:2];
    pop     = req & ~wbs_we_i & (reg_sel == 2'd0) & ~empty;
    ctrl_wr = req & wbs_we_i & (reg_sel == 2'd2) & wbs_sel_i[0];
    head    = mem_q[rd_ptr_q[AW-1:0]];
    wdata   = {seq_q, field_q, 16'(shift_q)};
  end

  // Capture FSM: next state, shift register, bit count and push request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    bits_d   = bits_q;
    push_req = 1'b0;
    if (frame_start_i) begin
      shift_d = '0;
      bits_d  = '0;
      state_d = S_ARMED;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ARMED: begin
          if (cmp_strobe_i) begin
            cnt_d   = 8'(SETTLE_CYCLES - 1);
            state_d = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == 8'd0) state_d = S_SAMPLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
        S_SAMPLE: begin
          shift_d = {shift_q[NUM_PD-2:0], cmp_s2_q};
          bits_d  = bits_q + 5'd1;
          state_d = (bits_d == 5'(NUM_PD)) ? S_PUSH : S_ARMED;
        end
        S_PUSH: begin
          push_req = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FIFO pointers, sequence counter, overflow and control register.
  always_comb begin
    push     = push_req & (~full | pop);
    ovf_set  = push_req & full & ~pop;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    seq_d    = push_req ? seq_q + 8'd1 : seq_q;
    irq_en_d = ctrl_wr ? wbs_dat_i[0] : irq_en_q;
    ovf_d    = ovf_q;
    if (ctrl_wr && wbs_dat_i[1]) ovf_d = 1'b0;
    if (ovf_set)                 ovf_d = 1'b1;
    cmp_s1_d = cmp_i;
    cmp_s2_d = cmp_s1_q;
`ifdef RLBP_POPCOUNT_EN
    field_d  = (state_q == S_SAMPLE) ? lbp_field(shift_d) : field_q;
`else
    field_d  = 8'h00;
`endif
  end

  // Register read mux, registered ack/data and interrupt.
  always_comb begin
    case (reg_sel)
      2'd0:    rdata = empty ? 32'd0 : head;
      2'd1:    rdata = {20'd0, busy, ovf_q, full, empty, 3'd0, level5};
      2'd2:    rdata = {31'd0, irq_en_q};
      default: rdata = 32'd0;
    endcase
    ack_d = req;
    dat_d = (req && !wbs_we_i) ? rdata : 32'd0;
    irq_d = irq_en_q & (~empty | ovf_q);
  end

  // State registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      bits_q   <= '0;
      seq_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
      cmp_s1_q <= 1'b0;
      cmp_s2_q <= 1'b0;
      field_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      bits_q   <= bits_d;
      seq_q    <= seq_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
      cmp_s1_q <= cmp_s1_d;
      cmp_s2_q <= cmp_s2_d;
      field_q  <= field_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers so need no reset.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

endmodule
